// File: rtl/reg_file_reader_pkg.sv
// Shared types and defaults for the register-file readback responder.
package reg_file_reader_pkg;

  localparam int WIDTH_DEFAULT = 8;
  localparam int DEPTH_DEFAULT = 4;

  // Reset value of every entry and of the response register.
  localparam logic [7:0] INIT_DEFAULT = 8'hde;

  // The response FSM has exactly two states; FULL is the state in which
  // a response is being presented (it is what resp_valid reports).
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage : reg_file_reader_pkg

// File: rtl/reg_file_reader_bank.sv
// Register bank: DEPTH entries reset to INIT, one write port, and one
// combinational read port that returns the data being written on the same
// edge when the addresses collide (write-first).
module reg_file_reader_bank
  import reg_file_reader_pkg::*;
#(
  parameter int              WIDTH = WIDTH_DEFAULT,
  parameter int              DEPTH = DEPTH_DEFAULT,
  parameter logic [WIDTH-1:0] INIT = WIDTH'(INIT_DEFAULT),
  localparam int             AW    = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             ASYNCRESET,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] entries [DEPTH];

  // Entry storage: async reset to INIT, otherwise a never-blocked write.
  // NOTE: this bank is a handful of flops, not a RAM macro, so resetting
  // every entry is cheap and gives the readback path a known value.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= INIT;
      end
    end else if (we) begin
      entries[waddr] <= wdata;
    end
  end

  // Write-first bypass: a read of the address being written sees wdata.
  assign rdata = (we && (waddr == raddr)) ? wdata : entries[raddr];

endmodule : reg_file_reader_bank

// File: rtl/reg_file_reader.sv
// Read-side responder: accepts read requests on a valid/ready channel and
// returns the addressed entry on a valid/ready response channel, with one
// response per cycle when the consumer keeps up.
module reg_file_reader
  import reg_file_reader_pkg::*;
#(
  parameter int              WIDTH = WIDTH_DEFAULT,
  parameter int              DEPTH = DEPTH_DEFAULT,
  parameter logic [WIDTH-1:0] INIT = WIDTH'(INIT_DEFAULT),
  localparam int             AW    = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             ASYNCRESET,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd_valid,
  output logic             rd_ready,
  input  logic [AW-1:0]    rd_addr,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic [7:0]       resp_count
);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] bank_rdata;
  logic [WIDTH-1:0] data_q;
  logic [7:0]       count_q;
  logic             accept;

  reg_file_reader_bank #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .INIT  (INIT)
  ) u_bank (
    .CLK        (CLK),
    .ASYNCRESET (ASYNCRESET),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .raddr      (rd_addr),
    .rdata      (bank_rdata)
  );

  assign accept = rd_valid && rd_ready;

  // State register.
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: fill on an accepted request, drain only when the consumer
  // takes the response and no new request replaces it.
  // NOTE: every always_comb output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (resp_ready && !rd_valid) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // Outputs: resp_valid mirrors the state; in FULL a new request can only
  // be taken when the current response leaves, so rd_ready follows
  // resp_ready combinationally.
  always_comb begin
    resp_valid = 1'b0;
    rd_ready   = 1'b1;
    case (state_q)
      EMPTY: begin
        resp_valid = 1'b0;
        rd_ready   = 1'b1;
      end
      FULL: begin
        resp_valid = 1'b1;
        rd_ready   = resp_ready;
      end
      default: begin
        resp_valid = 1'b0;
        rd_ready   = 1'b1;
      end
    endcase
  end

  // Response register: a snapshot taken only on accept, so later writes to
  // the same entry never disturb a held response.
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      data_q <= INIT;
    end else if (accept) begin
      data_q <= bank_rdata;
    end
  end

  // Completed-response counter, wrapping modulo 256.
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      count_q <= 8'd0;
    end else if (resp_valid && resp_ready) begin
      count_q <= count_q + 8'd1;
    end
  end

  assign resp_data  = data_q;
  assign resp_count = count_q;

endmodule : reg_file_reader

// File: tb/tb_reg_file_reader.sv
// Self-checking bench for reg_file_reader: stimulus predicts each response
// from a behavioural model of the register file and pushes it into a
// scoreboard queue; a monitor pops and compares on every presented response.
module tb_reg_file_reader;

  logic       CLK;
  logic       ASYNCRESET;
  logic       we;
  logic [1:0] waddr;
  logic [7:0] wdata;
  logic       rd_valid;
  logic       rd_ready;
  logic [1:0] rd_addr;
  logic       resp_valid;
  logic       resp_ready;
  logic [7:0] resp_data;
  logic [7:0] resp_count;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: the register contents, whether a response is
  // outstanding, and how many responses have completed.
  logic [7:0] m_mem [4];
  logic       m_valid;
  logic [7:0] m_count;
  logic [7:0] exp_q [$];

  reg_file_reader dut (
    .CLK        (CLK),
    .ASYNCRESET (ASYNCRESET),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_addr    (rd_addr),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_count (resp_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_mem[i] = 8'hde;
    m_valid = 1'b0;
    m_count = 8'd0;
    exp_q.delete();
  endtask

  // Called just after a rising edge: reset asynchronously, check the forced
  // values before any clock edge, then release and realign.
  task automatic apply_reset();
    ASYNCRESET = 1'b1;
    #1;
    check("rst_resp_valid", 32'(resp_valid), 32'h0);
    check("rst_resp_data", 32'(resp_data), 32'hde);
    check("rst_resp_count", 32'(resp_count), 32'h0);
    model_reset();
    #1;
    ASYNCRESET = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  // Drive one cycle of inputs, check handshake outputs against the model,
  // predict what the coming edge does, then advance one clock.
  task automatic step(input logic w, input logic [1:0] wa, input logic [7:0] wd,
                      input logic rv, input logic [1:0] ra, input logic rr);
    logic exp_ready;
    logic take;
    we = w; waddr = wa; wdata = wd;
    rd_valid = rv; rd_addr = ra; resp_ready = rr;
    #1;
    exp_ready = !m_valid || rr;
    check("rd_ready", 32'(rd_ready), 32'(exp_ready));
    check("resp_valid", 32'(resp_valid), 32'(m_valid));
    check("resp_count", 32'(resp_count), 32'(m_count));
    take = rv && exp_ready;
    if (m_valid && rr) m_count = m_count + 8'd1;
    if (take) begin
      exp_q.push_back((w && (wa == ra)) ? wd : m_mem[ra]);
      m_valid = 1'b1;
    end else if (m_valid && rr) begin
      m_valid = 1'b0;
    end
    if (w) m_mem[wa] = wd;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input logic rr);
    step(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, rr);
  endtask

  // Monitor: compare every presented response with the scoreboard head and
  // retire it once the consumer takes it.
  always @(negedge CLK) begin
    if (!ASYNCRESET && resp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: got response %0h expected none at %0t", resp_data, $time);
      end else begin
        check("resp_data", 32'(resp_data), 32'(exp_q[0]));
        if (resp_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    we = 1'b0; waddr = '0; wdata = '0;
    rd_valid = 1'b0; rd_addr = '0; resp_ready = 1'b0;
    apply_reset();

    // Reset value readback from address 2.
    step(1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 1'b1);
    check("first_resp", 32'(resp_data), 32'hde);
    idle(1'b1);
    check("first_count", 32'(resp_count), 32'd1);

    // Write then read.
    step(1'b1, 2'd1, 8'h5a, 1'b0, 2'd0, 1'b1);
    step(1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 1'b1);
    check("write_read", 32'(resp_data), 32'h5a);
    idle(1'b1);

    // Back-to-back streaming from a clean counter.
    apply_reset();
    step(1'b1, 2'd0, 8'h11, 1'b0, 2'd0, 1'b1);
    step(1'b1, 2'd1, 8'h22, 1'b0, 2'd0, 1'b1);
    step(1'b1, 2'd2, 8'h33, 1'b0, 2'd0, 1'b1);
    step(1'b1, 2'd3, 8'h44, 1'b0, 2'd0, 1'b1);
    for (int a = 0; a < 4; a++) step(1'b0, 2'd0, 8'h00, 1'b1, 2'(a), 1'b1);
    idle(1'b1);
    check("stream_count", 32'(resp_count), 32'd4);

    // Backpressure: the held response survives a rewrite of its entry.
    step(1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 1'b0);
    step(1'b1, 2'd3, 8'h99, 1'b1, 2'd2, 1'b0);
    check("bp_hold0", 32'(resp_data), 32'h44);
    step(1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 1'b0);
    check("bp_hold1", 32'(resp_data), 32'h44);
    step(1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 1'b0);
    check("bp_hold2", 32'(resp_data), 32'h44);
    step(1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 1'b1);
    check("bp_reread", 32'(resp_data), 32'h99);
    idle(1'b1);

    // Collision bypass, then a write to a different address than the read.
    step(1'b1, 2'd0, 8'hc3, 1'b1, 2'd0, 1'b1);
    check("collision", 32'(resp_data), 32'hc3);
    step(1'b1, 2'd1, 8'h77, 1'b1, 2'd2, 1'b1);
    check("no_collision", 32'(resp_data), 32'h33);
    idle(1'b1);

    // Randomized traffic with random backpressure.
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom),
           1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 3) != 0));
    end
    idle(1'b1);
    idle(1'b1);

    // Async reset while a response is held under backpressure.
    step(1'b1, 2'd1, 8'h3c, 1'b1, 2'd1, 1'b0);
    idle(1'b0);
    check("pre_rst_valid", 32'(resp_valid), 32'h1);
    check("pre_rst_data", 32'(resp_data), 32'h3c);
    apply_reset();
    for (int a = 0; a < 4; a++) begin
      step(1'b0, 2'd0, 8'h00, 1'b1, 2'(a), 1'b1);
      check("post_rst_read", 32'(resp_data), 32'hde);
    end
    idle(1'b1);
    idle(1'b1);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_reg_file_reader
